instruction_fetch_queue: RTL
============================

INSTRUCTION_FETCH_QUEUE -- requirements
Module: instruction_fetch_queue

Interface
REQ-001 Parameter ADDR_W, default 32: PC and target address width.
REQ-002 Parameter DATA_W, default 32: instruction width.
REQ-003 Parameter DEPTH, default 4: fetch-queue entries; power of two, 2..16.
REQ-004 Parameter RESET_PC, default 0: PC loaded on reset.
REQ-005 Ports: i_clk  in  1  clock, all state on rising edge.
REQ-006 Ports: i_reset  in  1  synchronous, active-low reset.
REQ-007 Ports: i_branch, i_zero  in  1 each  branch redirect = i_branch AND i_zero.
REQ-008 Ports: i_br_address  in  ADDR_W  branch target.
REQ-009 Ports: i_jump  in  1  jump redirect.
REQ-010 Ports: i_jmp_address  in  ADDR_W  jump target.
REQ-011 Ports: i_halt  in  1  suspend new memory requests.
REQ-012 Ports: o_imem_req  out  1  memory read request, one address per cycle.
REQ-013 Ports: o_imem_addr  out  ADDR_W  request address.
REQ-014 Ports: i_imem_rdata  in  DATA_W  read data, valid exactly 1 cycle after o_imem_req.
REQ-015 Ports: o_valid  out  1  queue head valid toward decode.
REQ-016 Ports: i_ready  in  1  decode accepts head.
REQ-017 Ports: o_instruction  out  DATA_W; o_pc  out  ADDR_W; o_pc_increment  out  ADDR_W  head entry fields.
REQ-018 Ports: o_count  out  $clog2(DEPTH)+1  occupied entries.

Function
REQ-019 FSM states: S_IDLE, S_FETCH, S_HALT.
REQ-020 Transitions: S_IDLE -> S_FETCH unconditionally one cycle after reset release.
REQ-021 Transitions: S_FETCH -> S_HALT when i_halt=1.
REQ-022 Transitions: S_HALT -> S_FETCH when i_halt=0; a redirect is accepted in any state.
REQ-023 o_imem_req=1 only in S_FETCH, with no redirect this cycle, and count + inflight < DEPTH.
REQ-024 inflight is 0 or 1, counting the request issued last cycle.
REQ-025 On a request, o_imem_addr=fetch PC, and fetch PC <= fetch PC + 4 (mod 2^ADDR_W, wraps silently).
REQ-026 Response cycle: push {i_imem_rdata, request PC, request PC+4}, unless dropped per REQ-028.
REQ-027 Redirect: i_jump has priority over (i_branch AND i_zero); fetch PC <= selected target next cycle.
REQ-028 Redirect: queue cleared next cycle; any response arriving the cycle after the redirect is dropped.
REQ-029 Redirect: o_imem_req=0 during the redirect cycle; first target request issued the following cycle.
REQ-030 o_valid=1 iff count>0; pop on o_valid AND i_ready.
REQ-031 Head outputs are stable while o_valid=1 AND i_ready=0.
REQ-032 Simultaneous push and pop: count unchanged, FIFO order preserved, pointers wrap modulo DEPTH.
REQ-033 Full queue: no request issued, so no overflow; pop on empty is ignored.
REQ-034 Redirect coinciding with pop: the flush wins and the pop is discarded.
REQ-035 Throughput: with i_ready held 1, one instruction per cycle sustained.
REQ-036 Latency: first o_valid three cycles after reset release.

Reset
REQ-037 While i_reset=0 at a clock edge: state <= S_IDLE, fetch PC <= RESET_PC, pointers/count/inflight <= 0.
REQ-038 During reset: o_imem_req=0, o_valid=0, o_count=0, o_instruction/o_pc/o_pc_increment=0.
REQ-039 Reset asserted mid-operation discards queue contents and any in-flight response.

Structure
REQ-040 Shared package ifq_pkg holds the FSM state encoding (2-bit) and the PC increment constant 4.
REQ-041 Queue storage and pointers live in one sub-module, fetch_fifo (parameters WIDTH, DEPTH; push/pop/clear/count).
REQ-042 Top holds the FSM, PC register, redirect mux and credit logic.

Verification
REQ-043 Reset release, RESET_PC=0, i_ready=1, rdata=addr+0x100 -> o_pc 0,4,8 on consecutive cycles; first o_valid three cycles after release.
REQ-044 i_ready=0 for 8 cycles -> o_count saturates at 4, o_imem_req=0, head stays pc=0.
REQ-045 i_branch=1, i_zero=1, i_br_address=0x40 with one response in flight -> queue cleared, stale response dropped, next o_pc=0x40.
REQ-046 i_jump=1 (i_jmp_address=0x80) and branch taken (0x40) in the same cycle -> next o_pc=0x80.
REQ-047 i_halt=1 for 3 cycles while the queue drains -> no requests issued; resume continues from the next sequential PC.
REQ-048 RESET_PC=0xFFFFFFFC -> o_pc 0xFFFFFFFC then 0x0; o_pc_increment for the first entry = 0x0.

Source files
------------

// File: rtl/ifq_pkg.sv
// Shared definitions for the instruction fetch queue: FSM encoding and PC step.
package ifq_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_HALT  = 2'd2
   } ifq_state_e;

   localparam int unsigned PcIncrement = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Circular FIFO holding fetched entries; clear drops everything on the next edge.
module fetch_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   clear_i,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       wdata_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       rdata_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [PW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   // Clear and reset take precedence over any push/pop in the same cycle.
   assign do_push = rst_ni && !clear_i && push_i && (count_q != (PW+1)'(DEPTH));
   assign do_pop  = rst_ni && !clear_i && pop_i && (count_q != '0);

   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetch front end: PC sequencing, branch/jump redirect and credit-limited requests
// into a fetch queue that feeds decode.
module instruction_fetch_queue #(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       DATA_W   = 32,
   parameter int unsigned       DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_branch,
   input  logic                   i_zero,
   input  logic [ADDR_W-1:0]      i_br_address,
   input  logic                   i_jump,
   input  logic [ADDR_W-1:0]      i_jmp_address,
   input  logic                   i_halt,
   output logic                   o_imem_req,
   output logic [ADDR_W-1:0]      o_imem_addr,
   input  logic [DATA_W-1:0]      i_imem_rdata,
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic [DATA_W-1:0]      o_instruction,
   output logic [ADDR_W-1:0]      o_pc,
   output logic [ADDR_W-1:0]      o_pc_increment,
   output logic [$clog2(DEPTH):0] o_count
);

   import ifq_pkg::*;

   localparam int unsigned       CW     = $clog2(DEPTH) + 1;
   localparam int unsigned       EW     = DATA_W + 2 * ADDR_W;
   localparam logic [ADDR_W-1:0] PcStep = ADDR_W'(PcIncrement);

   ifq_state_e        state_q;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] req_pc_q;
   logic              inflight_q;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;
   logic              req;
   logic [CW:0]       credit_used;
   logic [CW-1:0]     count;
   logic [EW-1:0]     head;
   logic [EW-1:0]     entry;
   logic              head_valid;
   logic              push;
   logic              pop;

   assign redirect    = i_jump | (i_branch & i_zero);
   assign redirect_pc = i_jump ? i_jmp_address : i_br_address;

   // Queued entries plus the outstanding response must never exceed the queue size.
   assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight_q};
   assign req = i_reset && (state_q == S_FETCH) && !redirect &&
                (credit_used < (CW+1)'(DEPTH));

   assign head_valid = i_reset && (count != '0);
   assign push       = inflight_q && !redirect;
   assign pop        = head_valid && i_ready && !redirect;
   assign entry      = {i_imem_rdata, req_pc_q, req_pc_q + PcStep};

   always_comb begin
      pc_d = pc_q;
      if (redirect) begin
         pc_d = redirect_pc;
      end else if (req) begin
         pc_d = pc_q + PcStep;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         req_pc_q   <= RESET_PC;
         inflight_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE:  state_q <= S_FETCH;
            S_FETCH: if (i_halt)  state_q <= S_HALT;
            S_HALT:  if (!i_halt) state_q <= S_FETCH;
            default: state_q <= S_IDLE;
         endcase
         pc_q       <= pc_d;
         inflight_q <= req;
         if (req) req_pc_q <= pc_q;
      end
   end

   fetch_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (i_clk),
      .rst_ni  (i_reset),
      .clear_i (redirect),
      .push_i  (push),
      .wdata_i (entry),
      .pop_i   (pop),
      .rdata_o (head),
      .count_o (count)
   );

   always_comb begin
      o_imem_req     = req;
      o_imem_addr    = pc_q;
      o_valid        = head_valid;
      o_count        = i_reset ? count : '0;
      o_instruction  = '0;
      o_pc           = '0;
      o_pc_increment = '0;
      if (head_valid) begin
         o_instruction  = head[EW-1:2*ADDR_W];
         o_pc           = head[2*ADDR_W-1:ADDR_W];
         o_pc_increment = head[ADDR_W-1:0];
      end
   end

endmodule
